// File: rtl/acl_txsched.sv
// ---------------------------------------------------------------------------
// acl_txsched : master-side ACL TX slot scheduler
//
// For each master TX slot this block chooses the LT_ADDR to address and what
// to send there: data (new or retransmitted), a POLL, or nothing. Data goes
// only to links whose remote FLOW is GO. A poll is due when a link's poll
// counter has reached regi_tpoll. After the slave's response header it tells
// the buffer logic to advance the TX buffer of an ACKed data link.
//
// Ports
//   clk_6M, rstz        clock, asynchronous active-low reset
//   sched_en            master connection active (low: IDLE, counters cleared)
//   ms_tslot_p          master TX slot start pulse
//   regi_link_active    per-LT_ADDR connected flags (bit0 ignored)
//   regi_txdatready     per-LT_ADDR ACL payload pending
//   dec_flow, dec_arqn  last received FLOW / ARQN per LT_ADDR
//   regi_tpoll          poll interval in slots, 0 disables polling
//   rx_resp_p/rx_hdr_ok response header done / header valid for this link
//   sched_p, sched_lt_addr, sched_kind   scheduling decision pulse
//   txbuf_adv_p, txbuf_adv_lt            TX buffer advance pulse
//   busy                FSM not in IDLE
// ---------------------------------------------------------------------------
module acl_txsched #(
    parameter int TPW = 16
) (
    input  logic           clk_6M,
    input  logic           rstz,
    input  logic           sched_en,
    input  logic           ms_tslot_p,
    input  logic [7:0]     regi_link_active,
    input  logic [7:0]     regi_txdatready,
    input  logic [7:0]     dec_flow,
    input  logic [7:0]     dec_arqn,
    input  logic [TPW-1:0] regi_tpoll,
    input  logic           rx_resp_p,
    input  logic           rx_hdr_ok,
    output logic           sched_p,
    output logic [2:0]     sched_lt_addr,
    output logic [1:0]     sched_kind,
    output logic           txbuf_adv_p,
    output logic [2:0]     txbuf_adv_lt,
    output logic           busy
);

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_DATA = 2'd1;
    localparam logic [1:0] KIND_POLL = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT_RSP
    } state_t;

    state_t               state;
    logic [2:0]           rr_last;
    logic [2:0]           lt_q;
    logic [1:0]           kind_q;
    logic [7:1][TPW-1:0]  cnt;

    logic                 poll_on;
    logic                 resp_clr;
    logic [7:0]           data_cand;
    logic [7:0]           poll_cand;
    logic [7:0]           sel;
    logic [2:0]           grant_lt;
    logic [1:0]           grant_kind;
    logic                 found;
    logic [3:0]           step_sum;

    assign poll_on  = (regi_tpoll != '0);
    assign resp_clr = (state == WAIT_RSP) && rx_resp_p && rx_hdr_ok;
    assign busy     = (state != IDLE);

    // Candidate vectors; bit0 is masked so LT_ADDR 0 can never be granted.
    always_comb begin
        data_cand    = regi_link_active & regi_txdatready & dec_flow & 8'hFE;
        poll_cand    = '0;
        for (int unsigned i = 1; i <= 7; i++) begin
            poll_cand[3'(i)] = regi_link_active[3'(i)] & poll_on &
                               (cnt[3'(i)] >= regi_tpoll);
        end
    end

    // Round-robin search from rr_last+1 upward, wrapping 7 -> 1.
    always_comb begin
        sel        = '0;
        grant_lt   = '0;
        grant_kind = KIND_NONE;
        found      = 1'b0;
        step_sum   = '0;
        if (|data_cand) begin
            sel        = data_cand;
            grant_kind = KIND_DATA;
        end else if (|poll_cand) begin
            sel        = poll_cand;
            grant_kind = KIND_POLL;
        end
        for (int unsigned k = 1; k <= 7; k++) begin
            step_sum = {1'b0, rr_last} + 4'(k);
            if (step_sum > 4'd7) begin
                step_sum = step_sum - 4'd7;
            end
            if (!found && sel[step_sum[2:0]]) begin
                found    = 1'b1;
                grant_lt = step_sum[2:0];
            end
        end
    end

    // Poll counters: clears outrank the response clear, which outranks the
    // slot increment; the count saturates at all-ones.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            cnt <= '0;
        end else begin
            for (int unsigned i = 1; i <= 7; i++) begin
                if (!sched_en || !regi_link_active[3'(i)] || !poll_on) begin
                    cnt[3'(i)] <= '0;
                end else if (resp_clr && (lt_q == 3'(i))) begin
                    cnt[3'(i)] <= '0;
                end else if (ms_tslot_p && (cnt[3'(i)] != '1)) begin
                    cnt[3'(i)] <= cnt[3'(i)] + TPW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state         <= IDLE;
            rr_last       <= 3'd7;
            lt_q          <= '0;
            kind_q        <= KIND_NONE;
            sched_p       <= 1'b0;
            sched_lt_addr <= '0;
            sched_kind    <= KIND_NONE;
            txbuf_adv_p   <= 1'b0;
            txbuf_adv_lt  <= '0;
        end else begin
            sched_p     <= 1'b0;
            txbuf_adv_p <= 1'b0;
            if (!sched_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ms_tslot_p) begin
                            state <= ARB;
                        end
                    end
                    ARB: begin
                        lt_q          <= grant_lt;
                        kind_q        <= grant_kind;
                        sched_p       <= 1'b1;
                        sched_lt_addr <= grant_lt;
                        sched_kind    <= grant_kind;
                        state         <= ISSUE;
                    end
                    ISSUE: begin
                        if (kind_q != KIND_NONE) begin
                            rr_last <= lt_q;
                            state   <= WAIT_RSP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    WAIT_RSP: begin
                        // A response coinciding with the next slot is handled
                        // first, then arbitration starts for that slot.
                        if (rx_resp_p) begin
                            if (rx_hdr_ok && (kind_q == KIND_DATA) && dec_arqn[lt_q]) begin
                                txbuf_adv_p  <= 1'b1;
                                txbuf_adv_lt <= lt_q;
                            end
                            state <= ms_tslot_p ? ARB : IDLE;
                        end else if (ms_tslot_p) begin
                            state <= ARB;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acl_txsched.sv
// ---------------------------------------------------------------------------
// tb_acl_txsched : self-checking bench for acl_txsched
//
// A slot-level reference model (poll counters as integers, round-robin as a
// wrap-around walk over LT_ADDR 1..7) predicts every scheduling decision and
// buffer-advance pulse. Directed scenarios come first, then randomized slots.
// A narrow counter width is used so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_acl_txsched;

    localparam int TPW  = 3;
    localparam int CMAX = (1 << TPW) - 1;

    logic           clk_6M = 1'b0;
    logic           rstz = 1'b0;
    logic           sched_en = 1'b0;
    logic           ms_tslot_p = 1'b0;
    logic [7:0]     regi_link_active = '0;
    logic [7:0]     regi_txdatready = '0;
    logic [7:0]     dec_flow = '0;
    logic [7:0]     dec_arqn = '0;
    logic [TPW-1:0] regi_tpoll = '0;
    logic           rx_resp_p = 1'b0;
    logic           rx_hdr_ok = 1'b0;
    logic           sched_p;
    logic [2:0]     sched_lt_addr;
    logic [1:0]     sched_kind;
    logic           txbuf_adv_p;
    logic [2:0]     txbuf_adv_lt;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt [1:7];
    int m_rr;
    int cur_lt;
    int cur_kind;
    bit in_wait;

    acl_txsched #(.TPW(TPW)) dut (
        .clk_6M           (clk_6M),
        .rstz             (rstz),
        .sched_en         (sched_en),
        .ms_tslot_p       (ms_tslot_p),
        .regi_link_active (regi_link_active),
        .regi_txdatready  (regi_txdatready),
        .dec_flow         (dec_flow),
        .dec_arqn         (dec_arqn),
        .regi_tpoll       (regi_tpoll),
        .rx_resp_p        (rx_resp_p),
        .rx_hdr_ok        (rx_hdr_ok),
        .sched_p          (sched_p),
        .sched_lt_addr    (sched_lt_addr),
        .sched_kind       (sched_kind),
        .txbuf_adv_p      (txbuf_adv_p),
        .txbuf_adv_lt     (txbuf_adv_lt),
        .busy             (busy)
    );

    always #5 clk_6M = ~clk_6M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 1; i <= 7; i++) m_cnt[i] = 0;
        m_rr     = 7;
        cur_lt   = 0;
        cur_kind = 0;
        in_wait  = 0;
    endtask

    // Slot start: counters advance unless cleared; clr_lt names a link whose
    // counter is cleared by a response in the same cycle (0 = none).
    task automatic model_tslot(input int clr_lt);
        for (int i = 1; i <= 7; i++) begin
            if (!regi_link_active[i] || regi_tpoll == 0) m_cnt[i] = 0;
            else if (i == clr_lt)                        m_cnt[i] = 0;
            else if (m_cnt[i] < CMAX)                    m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    task automatic model_grant(output int lt, output int kind);
        lt   = 0;
        kind = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int step = 1; step <= 7; step++) begin
                int  i;
                bit  c;
                i = m_rr + step;
                if (i > 7) i = i - 7;
                if (pass == 0) c = regi_link_active[i] && regi_txdatready[i] && dec_flow[i];
                else           c = regi_link_active[i] && (regi_tpoll != 0) && (m_cnt[i] >= regi_tpoll);
                if (c && kind == 0) begin
                    lt   = i;
                    kind = pass + 1;
                end
            end
        end
    endtask

    // Drive one slot pulse (optionally with a response in the same cycle) and
    // follow it through to the cycle after the scheduling pulse.
    task automatic issue_slot(input bit with_resp, input bit ok);
        int g_lt, g_kind, clr;
        bit exp_adv;
        clr     = 0;
        exp_adv = 0;
        if (with_resp) begin
            rx_resp_p = 1'b1;
            rx_hdr_ok = ok;
            if (ok) clr = cur_lt;
            exp_adv = ok && (cur_kind == 1) && dec_arqn[cur_lt];
        end
        ms_tslot_p = 1'b1;
        model_tslot(clr);
        model_grant(g_lt, g_kind);
        tick();
        ms_tslot_p = 1'b0;
        rx_resp_p  = 1'b0;
        rx_hdr_ok  = 1'b0;
        check("busy_arb", busy, 1);
        check("sched_early", sched_p, 0);
        check("adv_p_slot", txbuf_adv_p, exp_adv);
        if (exp_adv) check("adv_lt_slot", txbuf_adv_lt, cur_lt);
        tick();
        check("sched_p", sched_p, 1);
        check("sched_lt", sched_lt_addr, g_lt);
        check("sched_kind", sched_kind, g_kind);
        check("adv_once_slot", txbuf_adv_p, 0);
        tick();
        check("sched_once", sched_p, 0);
        check("busy_after_issue", busy, (g_kind != 0));
        if (g_kind != 0) m_rr = g_lt;
        cur_lt   = g_lt;
        cur_kind = g_kind;
        in_wait  = (g_kind != 0);
    endtask

    task automatic respond(input bit ok);
        bit exp_adv;
        exp_adv   = ok && (cur_kind == 1) && dec_arqn[cur_lt];
        rx_resp_p = 1'b1;
        rx_hdr_ok = ok;
        if (ok) m_cnt[cur_lt] = 0;
        tick();
        rx_resp_p = 1'b0;
        rx_hdr_ok = 1'b0;
        check("adv_p", txbuf_adv_p, exp_adv);
        if (exp_adv) check("adv_lt", txbuf_adv_lt, cur_lt);
        check("busy_after_resp", busy, 0);
        tick();
        check("adv_once", txbuf_adv_p, 0);
        in_wait = 0;
    endtask

    task automatic rand_inputs();
        if ($urandom_range(0, 7) == 0) begin
            regi_link_active = 8'($urandom | $urandom);
            regi_tpoll       = TPW'($urandom_range(0, CMAX));
        end
        regi_txdatready = 8'($urandom & $urandom);
        dec_flow        = 8'($urandom | $urandom);
        dec_arqn        = 8'($urandom);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        check("rst_sched_p", sched_p, 0);
        check("rst_lt", sched_lt_addr, 0);
        check("rst_kind", sched_kind, 0);
        check("rst_adv_p", txbuf_adv_p, 0);
        check("rst_adv_lt", txbuf_adv_lt, 0);
        check("rst_busy", busy, 0);
        rstz     = 1'b1;
        sched_en = 1'b1;
        tick();

        // Data on two links, round-robin after an ACKed response.
        regi_link_active = 8'h06; regi_txdatready = 8'h06; dec_flow = 8'hFF;
        regi_tpoll = '0; dec_arqn = 8'hFF;
        issue_slot(0, 0);
        respond(1);
        issue_slot(0, 0);
        respond(1);

        // FLOW=STOP: only a poll after three slots, then the counter restarts.
        regi_link_active = 8'h02; regi_txdatready = 8'h02; dec_flow = 8'h00;
        regi_tpoll = TPW'(3);
        repeat (3) issue_slot(0, 0);
        respond(1);
        issue_slot(0, 0);

        // NAK: no advance, same link rescheduled.
        dec_flow = 8'h02; regi_tpoll = '0; dec_arqn = 8'h00;
        issue_slot(0, 0);
        respond(1);
        issue_slot(0, 0);
        dec_arqn = 8'hFF;
        respond(1);

        // Missing response: next slot arbitrates directly, counter kept.
        dec_flow = 8'h00; regi_tpoll = TPW'(3);
        repeat (3) issue_slot(0, 0);
        issue_slot(0, 0);
        respond(1);

        // Response and slot pulse together.
        dec_flow = 8'h02; regi_tpoll = '0; dec_arqn = 8'hFF;
        issue_slot(0, 0);
        issue_slot(1, 1);
        respond(1);

        // sched_en dropped while waiting for a data response.
        regi_link_active = 8'h06; regi_txdatready = 8'h04; dec_flow = 8'h04;
        regi_tpoll = TPW'(3); dec_arqn = 8'hFF;
        repeat (3) issue_slot(0, 0);
        sched_en = 1'b0;
        for (int i = 1; i <= 7; i++) m_cnt[i] = 0;
        in_wait = 0;
        tick();
        check("en_off_busy", busy, 0);
        rx_resp_p = 1'b1; rx_hdr_ok = 1'b1;
        tick();
        rx_resp_p = 1'b0; rx_hdr_ok = 1'b0;
        check("en_off_adv", txbuf_adv_p, 0);
        check("en_off_sched", sched_p, 0);
        sched_en = 1'b1;
        regi_txdatready = 8'h00; dec_flow = 8'h00;
        tick();
        issue_slot(0, 0);

        // Reset while the scheduling pulse is out.
        regi_link_active = 8'h02; regi_txdatready = 8'h02; dec_flow = 8'h02;
        ms_tslot_p = 1'b1;
        tick();
        ms_tslot_p = 1'b0;
        tick();
        check("pre_rst_sched_p", sched_p, 1);
        rstz = 1'b0;
        #1;
        check("mid_rst_sched_p", sched_p, 0);
        check("mid_rst_lt", sched_lt_addr, 0);
        check("mid_rst_kind", sched_kind, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_adv", txbuf_adv_p, 0);
        tick();
        tick();
        rstz = 1'b1;
        model_reset();
        tick();

        // Randomized slots.
        regi_link_active = 8'hFE; regi_tpoll = TPW'(5);
        for (int it = 0; it < 400; it++) begin
            if (in_wait && $urandom_range(0, 2) == 0) begin
                dec_arqn = 8'($urandom);
                respond($urandom_range(0, 3) != 0);
            end else if (in_wait) begin
                rand_inputs();
                issue_slot(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            end else begin
                repeat ($urandom_range(0, 2)) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rx_resp_p = 1'b1;
                        rx_hdr_ok = 1'b1;
                    end
                    tick();
                    rx_resp_p = 1'b0;
                    rx_hdr_ok = 1'b0;
                    check("idle_no_adv", txbuf_adv_p, 0);
                    check("idle_no_sched", sched_p, 0);
                end
                rand_inputs();
                issue_slot(0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
